// File: rtl/food_pkg.sv
// Shared vending constants: coin values, accumulator states and product prices.
// The menu imports this package too, so prices live in one place.
package food_pkg;

  localparam logic [5:0] MOEDA5  = 6'd5;
  localparam logic [5:0] MOEDA10 = 6'd10;
  localparam logic [5:0] MOEDA25 = 6'd25;

  localparam logic [5:0] PRECO_A = 6'd45;
  localparam logic [5:0] PRECO_B = 6'd40;
  localparam logic [5:0] PRECO_C = 6'd30;
  localparam logic [5:0] PRECO_D = 6'd25;

  typedef enum logic {
    IDLE,
    TROCO
  } state_e;

  // Largest change coin not exceeding the balance; 0 for a sub-coin residue.
  function automatic logic [5:0] troco_coin(input logic [5:0] saldo);
    if (saldo >= MOEDA25)      return MOEDA25;
    else if (saldo >= MOEDA10) return MOEDA10;
    else if (saldo >= MOEDA5)  return MOEDA5;
    else                       return 6'd0;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Active-low button conditioner: 2-flop synchronizer, stability counter, and a
// registered one-clock press pulse on the accepted high-to-low transition.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
      else                                   cnt_d   = cnt_q + 1'b1;
    end
    press_d = level_prev_q & ~level_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      level_q      <= 1'b1;
      level_prev_q <= 1'b1;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_n;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/credit_accumulator.sv
// Coin credit stage: accumulates debounced coin presses into saldoOut, debits
// menu purchases and pays the balance back as spaced change pulses on cancel.
module credit_accumulator import food_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CHANGE_GAP      = 25000000,
  parameter int SALDO_MAX       = 63
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin5_n,
  input  logic       coin10_n,
  input  logic       coin25_n,
  input  logic       cancel_n,
  input  logic [5:0] gastoIn,
  output logic [5:0] saldoOut,
  output logic       coin_reject,
  output logic       debit_error,
  output logic       troco_valid,
  output logic [5:0] troco_value,
  output logic       busy
);

  localparam int GW = (CHANGE_GAP > 1) ? $clog2(CHANGE_GAP) : 1;

  logic press5, press10, press25, press_cancel;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db5 (
    .clock(clock), .reset(reset), .btn_n(coin5_n), .press(press5));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db10 (
    .clock(clock), .reset(reset), .btn_n(coin10_n), .press(press10));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db25 (
    .clock(clock), .reset(reset), .btn_n(coin25_n), .press(press25));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbc (
    .clock(clock), .reset(reset), .btn_n(cancel_n), .press(press_cancel));

  state_e          state_q, state_d;
  logic [5:0]      saldo_q, saldo_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [5:0]      gasto_q;
  logic            gasto_nz_q, gasto_nz_d;
  logic [2:0]      pend_q, pend_d;          // {25, 10, 5}
  logic            coin_reject_q, coin_reject_d;
  logic            debit_error_q, debit_error_d;
  logic            troco_valid_q, troco_valid_d;
  logic [5:0]      troco_value_q, troco_value_d;

  logic            debit_ev;
  logic [2:0]      coin_req, coin_sel;
  logic [5:0]      coin_v;
  logic [6:0]      coin_sum;

  // A coin that loses arbitration stays in pend_q until it is served.
  assign coin_req = pend_q | {press25, press10, press5};
  assign coin_sel = coin_req[2] ? 3'b100 : coin_req[1] ? 3'b010 : coin_req[0] ? 3'b001 : 3'b000;
  assign coin_v   = coin_sel[2] ? MOEDA25 : coin_sel[1] ? MOEDA10 : coin_sel[0] ? MOEDA5 : 6'd0;
  assign coin_sum = {1'b0, saldo_q} + {1'b0, coin_v};
  assign debit_ev = (gasto_q != 6'd0) && !gasto_nz_q;

  always_comb begin
    state_d       = state_q;
    saldo_d       = saldo_q;
    gap_d         = gap_q;
    pend_d        = pend_q;
    gasto_nz_d    = (gasto_q != 6'd0);
    coin_reject_d = 1'b0;
    debit_error_d = 1'b0;
    troco_valid_d = 1'b0;
    troco_value_d = 6'd0;
    case (state_q)
      IDLE: begin
        if (debit_ev) begin
          pend_d = coin_req;
          if (gasto_q <= saldo_q) saldo_d       = saldo_q - gasto_q;
          else                    debit_error_d = 1'b1;
        end else if (press_cancel && saldo_q != 6'd0) begin
          pend_d  = coin_req;
          state_d = TROCO;
          gap_d   = '0;
        end else if (coin_req != 3'b000) begin
          pend_d = coin_req & ~coin_sel;
          if (coin_sum <= 7'(SALDO_MAX)) saldo_d       = saldo_q + coin_v;
          else                           coin_reject_d = 1'b1;
        end
      end
      TROCO: begin
        pend_d        = 3'b000;
        coin_reject_d = (coin_req != 3'b000);
        debit_error_d = debit_ev;
        if (saldo_q == 6'd0) begin
          state_d = IDLE;
        end else if (gap_q == '0) begin
          troco_value_d = troco_coin(saldo_q);
          troco_valid_d = (troco_value_d != 6'd0);
          saldo_d       = troco_valid_d ? saldo_q - troco_value_d : 6'd0;
          gap_d         = GW'(CHANGE_GAP - 1);
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      saldo_q       <= 6'd0;
      gap_q         <= '0;
      gasto_q       <= 6'd0;
      gasto_nz_q    <= 1'b0;
      pend_q        <= 3'b000;
      coin_reject_q <= 1'b0;
      debit_error_q <= 1'b0;
      troco_valid_q <= 1'b0;
      troco_value_q <= 6'd0;
    end else begin
      state_q       <= state_d;
      saldo_q       <= saldo_d;
      gap_q         <= gap_d;
      gasto_q       <= gastoIn;
      gasto_nz_q    <= gasto_nz_d;
      pend_q        <= pend_d;
      coin_reject_q <= coin_reject_d;
      debit_error_q <= debit_error_d;
      troco_valid_q <= troco_valid_d;
      troco_value_q <= troco_value_d;
    end
  end

  assign saldoOut    = saldo_q;
  assign coin_reject = coin_reject_q;
  assign debit_error = debit_error_q;
  assign troco_valid = troco_valid_q;
  assign troco_value = troco_value_q;
  assign busy        = (state_q == TROCO);

endmodule

// File: tb/tb_credit_accumulator.sv
// Bench for credit_accumulator: directed table, timing corner cases and random
// operation sequences checked against a balance-level model.
module tb_credit_accumulator;

  localparam int D    = 4;
  localparam int GAP  = 3;
  localparam int SMAX = 63;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       coin5_n = 1'b1, coin10_n = 1'b1, coin25_n = 1'b1, cancel_n = 1'b1;
  logic [5:0] gastoIn = 6'd0;
  logic [5:0] saldoOut, troco_value;
  logic       coin_reject, debit_error, troco_valid, busy;

  credit_accumulator #(.DEBOUNCE_CYCLES(D), .CHANGE_GAP(GAP), .SALDO_MAX(SMAX)) dut (
    .clock(clock), .reset(reset),
    .coin5_n(coin5_n), .coin10_n(coin10_n), .coin25_n(coin25_n), .cancel_n(cancel_n),
    .gastoIn(gastoIn), .saldoOut(saldoOut), .coin_reject(coin_reject),
    .debit_error(debit_error), .troco_valid(troco_valid), .troco_value(troco_value),
    .busy(busy));

  always #5 clock = ~clock;

  typedef enum int {OP_C5, OP_C10, OP_C25, OP_GLITCH, OP_DEBIT, OP_CANCEL, OP_CANCEL_COIN} op_e;
  typedef struct {
    op_e op;
    int  arg;
    int  exp_saldo;
    int  exp_rej;
    int  exp_err;
    int  exp_ntroco;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rej_cnt = 0, err_cnt = 0, busy_bad = 0, tval_bad = 0;
  int tv_q[$];
  int tc_q[$];
  int model_bal = 0;

  // Pulse monitor: counts every clock a pulse output is high.
  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      if (coin_reject) rej_cnt++;
      if (debit_error) err_cnt++;
      if (troco_valid) begin
        tv_q.push_back(int'(troco_value));
        tc_q.push_back(cyc);
        if (!busy) busy_bad++;
      end else if (troco_value != 6'd0) begin
        tval_bad++;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic hold(input logic [3:0] m, input int n);
    {cancel_n, coin25_n, coin10_n, coin5_n} = ~m;
    tick(n);
    {cancel_n, coin25_n, coin10_n, coin5_n} = 4'b1111;
  endtask

  function automatic int change_coin(input int b);
    if (b >= 25) return 25;
    if (b >= 10) return 10;
    if (b >= 5)  return 5;
    return 0;
  endfunction

  function automatic int n_change(input int b);
    int n = 0;
    while (change_coin(b) != 0) begin
      b -= change_coin(b);
      n++;
    end
    return n;
  endfunction

  task automatic run_op(input vec_t v);
    int rem;
    rem = model_bal;
    rej_cnt = 0; err_cnt = 0; busy_bad = 0; tval_bad = 0;
    tv_q.delete(); tc_q.delete();
    case (v.op)
      OP_C5:          begin hold(4'b0001, D + 4); tick(D + 8); end
      OP_C10:         begin hold(4'b0010, D + 4); tick(D + 8); end
      OP_C25:         begin hold(4'b0100, D + 4); tick(D + 8); end
      OP_GLITCH:      begin hold(4'b0001, 2);     tick(D + 8); end
      OP_DEBIT:       begin gastoIn = 6'(v.arg); tick(10); gastoIn = 6'd0; tick(4); end
      OP_CANCEL:      begin hold(4'b1000, D + 4); tick(60); end
      OP_CANCEL_COIN: begin hold(4'b1001, D + 4); tick(60); end
      default: ;
    endcase
    check($sformatf("op%0d saldo", v.op), int'(saldoOut), v.exp_saldo);
    check($sformatf("op%0d coin_reject", v.op), rej_cnt, v.exp_rej);
    check($sformatf("op%0d debit_error", v.op), err_cnt, v.exp_err);
    check($sformatf("op%0d troco_count", v.op), tv_q.size(), v.exp_ntroco);
    check($sformatf("op%0d troco_value_idle", v.op), tval_bad, 0);
    check($sformatf("op%0d busy_end", v.op), int'(busy), 0);
    if (v.op == OP_CANCEL || v.op == OP_CANCEL_COIN) begin
      check("troco_busy", busy_bad, 0);
      for (int i = 0; i < tv_q.size(); i++) begin
        check($sformatf("troco_value[%0d]", i), tv_q[i], change_coin(rem));
        rem -= change_coin(rem);
        if (i > 0) check($sformatf("troco_gap[%0d]", i), tc_q[i] - tc_q[i-1], GAP);
      end
    end
    model_bal = v.exp_saldo;
  endtask

  task automatic op(input op_e o, input int arg, input int s, input int r, input int e, input int n);
    vec_t v;
    v.op = o; v.arg = arg; v.exp_saldo = s; v.exp_rej = r; v.exp_err = e; v.exp_ntroco = n;
    run_op(v);
  endtask

  // Reference model: predicts the result of one isolated operation.
  task automatic model_op(input op_e o, input int arg);
    int b, r, e, n, cv;
    b = model_bal; r = 0; e = 0; n = 0;
    cv = (o == OP_C5) ? 5 : (o == OP_C10) ? 10 : (o == OP_C25) ? 25 : 0;
    if (cv != 0) begin
      if (b + cv <= SMAX) b += cv;
      else r = 1;
    end else if (o == OP_DEBIT) begin
      if (arg <= b) b -= arg;
      else e = 1;
    end else if (o == OP_CANCEL) begin
      n = n_change(b);
      b = 0;
    end
    op(o, arg, b, r, e, n);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " saldoOut"}, int'(saldoOut), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " troco_valid"}, int'(troco_valid), 0);
    check({tag, " troco_value"}, int'(troco_value), 0);
    check({tag, " coin_reject"}, int'(coin_reject), 0);
    check({tag, " debit_error"}, int'(debit_error), 0);
  endtask

  initial begin
    vec_t tbl[18];
    int   n;
    op_e  rop;

    tbl[0]  = '{OP_C25,         0, 25, 0, 0, 0};
    tbl[1]  = '{OP_C10,         0, 35, 0, 0, 0};
    tbl[2]  = '{OP_C10,         0, 45, 0, 0, 0};
    tbl[3]  = '{OP_GLITCH,      0, 45, 0, 0, 0};
    tbl[4]  = '{OP_DEBIT,      45,  0, 0, 0, 0};
    tbl[5]  = '{OP_CANCEL,      0,  0, 0, 0, 0};
    tbl[6]  = '{OP_C25,         0, 25, 0, 0, 0};
    tbl[7]  = '{OP_C25,         0, 50, 0, 0, 0};
    tbl[8]  = '{OP_C5,          0, 55, 0, 0, 0};
    tbl[9]  = '{OP_C5,          0, 60, 0, 0, 0};
    tbl[10] = '{OP_C5,          0, 60, 1, 0, 0};
    tbl[11] = '{OP_DEBIT,      30, 30, 0, 0, 0};
    tbl[12] = '{OP_DEBIT,      40, 30, 0, 1, 0};
    tbl[13] = '{OP_C10,         0, 40, 0, 0, 0};
    tbl[14] = '{OP_CANCEL,      0,  0, 0, 0, 3};
    tbl[15] = '{OP_C25,         0, 25, 0, 0, 0};
    tbl[16] = '{OP_C10,         0, 35, 0, 0, 0};
    tbl[17] = '{OP_CANCEL_COIN, 0,  0, 1, 0, 2};

    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    tick(2);

    // Coin latency: 2 sync + D debounce + 1 edge + 1 update.
    coin5_n = 1'b0;
    n = 0;
    while (n < 40 && saldoOut == 6'd0) begin tick(1); n++; end
    check("coin_latency", n, 2 + D + 1 + 1);
    check("coin_latency saldo", int'(saldoOut), 5);
    coin5_n = 1'b1;
    tick(D + 8);

    // Debit latency: edge register + update.
    gastoIn = 6'd5;
    n = 0;
    while (n < 40 && saldoOut != 6'd0) begin tick(1); n++; end
    check("debit_latency", n, 2);
    gastoIn = 6'd0;
    tick(4);
    model_bal = 0;

    foreach (tbl[i]) run_op(tbl[i]);

    // Coin-10 event and debit edge land on the same clock.
    op(OP_C25, 0, 25, 0, 0, 0);
    op(OP_C5,  0, 30, 0, 0, 0);
    rej_cnt = 0; err_cnt = 0;
    coin10_n = 1'b0;
    tick(6);
    gastoIn = 6'd25;
    tick(1); check("simul before", int'(saldoOut), 30);
    tick(1); check("simul debit", int'(saldoOut), 5);
    tick(1); check("simul coin", int'(saldoOut), 15);
    tick(4);
    coin10_n = 1'b1;
    gastoIn = 6'd0;
    tick(D + 8);
    check("simul saldo hold", int'(saldoOut), 15);
    check("simul no error", err_cnt + rej_cnt, 0);
    model_bal = 15;

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0: rop = OP_C5;
        1: rop = OP_C10;
        2: rop = OP_C25;
        3: rop = OP_C25;
        4: rop = OP_DEBIT;
        default: rop = OP_CANCEL;
      endcase
      model_op(rop, int'($urandom_range(1, 12)) * 5);
    end

    // Reset while change is being paid out.
    model_op(OP_CANCEL, 0);
    model_op(OP_C25, 0);
    model_op(OP_C10, 0);
    check("pre-reset saldo", int'(saldoOut), 35);
    cancel_n = 1'b0;
    n = 0;
    while (n < 40 && !troco_valid) begin tick(1); n++; end
    check("reset troco started", int'(busy), 1);
    reset = 1'b1;
    cancel_n = 1'b1;
    #1;
    check_all_zero("mid-troco reset");
    tick(3);
    reset = 1'b0;
    tick(2);
    model_bal = 0;
    op(OP_C5, 0, 5, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
